// File: rtl/sig_session_ctrl.sv
// sig_session_ctrl
// Initiator-side sequencer for the response compactor's memory-mapped port.
// A session accepts num_words 16-bit response words and turns each accepted
// word into one compactor write. It then reads the raw 32-bit signature back
// and compares it against a golden value latched when the session started.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle session request, honoured only in IDLE
//   num_words           word count for the session, sampled on accepted start
//   golden_sig          expected signature, sampled on accepted start
//   in_valid/in_ready   response word handshake; in_data carries the word
//   mem_access_addr     compactor address
//   mem_write_data      compactor write data
//   mem_write_en        compactor write strobe
//   mem_read_data       compactor read data (combinational from the address)
//   busy                session in progress
//   done                one-cycle pulse at session end
//   pass                result of the last session
//   timeout_err         last session was aborted by the idle timeout
//   signature           signature captured by the last session
//   dbg_state           current FSM state (0 IDLE, 1 COMPACT, 2 READ, 3 REPORT)
//
// Handshake: a word transfers in any cycle where in_valid and in_ready are
// both high; in_ready never depends on in_valid, and in_valid is never
// required to stay high when in_ready is low.
module sig_session_ctrl #(
  parameter logic [15:0] ADDR_BASE = 16'h0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num_words,
  input  logic [31:0] golden_sig,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [15:0] mem_access_addr,
  output logic [15:0] mem_write_data,
  output logic        mem_write_en,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] signature,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPACT = 2'd1,
    ST_READ    = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);
  // The raw signature view lives at the base address with bit0 clear.
  localparam logic [15:0] SIG_ADDR  = {ADDR_BASE[15:1], 1'b0};

  state_t      state_q, state_d;
  logic [15:0] num_words_q, num_words_d;
  logic [31:0] golden_q, golden_d;
  logic [15:0] addr_idx_q, addr_idx_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        pass_q, pass_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] signature_q, signature_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      num_words_q   <= 16'h0000;
      golden_q      <= 32'h0000_0000;
      addr_idx_q    <= 16'h0000;
      word_cnt_q    <= 16'h0000;
      idle_cnt_q    <= 16'h0000;
      pass_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      signature_q   <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      num_words_q   <= num_words_d;
      golden_q      <= golden_d;
      addr_idx_q    <= addr_idx_d;
      word_cnt_q    <= word_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      pass_q        <= pass_d;
      timeout_err_q <= timeout_err_d;
      signature_q   <= signature_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    num_words_d     = num_words_q;
    golden_d        = golden_q;
    addr_idx_d      = addr_idx_q;
    word_cnt_d      = word_cnt_q;
    idle_cnt_d      = idle_cnt_q;
    pass_d          = pass_q;
    timeout_err_d   = timeout_err_q;
    signature_d     = signature_q;
    in_ready        = 1'b0;
    mem_access_addr = 16'h0000;
    mem_write_data  = 16'h0000;
    mem_write_en    = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_words_d   = num_words;
          golden_d      = golden_sig;
          pass_d        = 1'b0;
          timeout_err_d = 1'b0;
          addr_idx_d    = 16'h0000;
          word_cnt_d    = 16'h0000;
          idle_cnt_d    = 16'h0000;
          state_d       = (num_words == 16'h0000) ? ST_READ : ST_COMPACT;
        end
      end

      ST_COMPACT: begin
        busy            = 1'b1;
        in_ready        = 1'b1;
        mem_access_addr = ADDR_BASE + addr_idx_q;
        if (in_valid) begin
          // Write goes out in the same cycle the word is accepted.
          mem_write_en   = 1'b1;
          mem_write_data = in_data;
          addr_idx_d     = addr_idx_q + 16'd2;
          word_cnt_d     = word_cnt_q + 16'd1;
          idle_cnt_d     = 16'h0000;
          // Exact compare, so num_words=16'hFFFF terminates without wrap.
          if (word_cnt_d == num_words_q) begin
            state_d = ST_READ;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
          if ((TIMEOUT != 0) && (idle_cnt_d == TIMEOUT_L)) begin
            state_d       = ST_REPORT;
            timeout_err_d = 1'b1;
            pass_d        = 1'b0;
          end
        end
      end

      ST_READ: begin
        busy            = 1'b1;
        mem_access_addr = SIG_ADDR;
        signature_d     = mem_read_data;
        pass_d          = (mem_read_data == golden_q);
        state_d         = ST_REPORT;
      end

      ST_REPORT: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign pass        = pass_q;
  assign timeout_err = timeout_err_q;
  assign signature   = signature_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sig_session_ctrl.sv
// Directed testbench for sig_session_ctrl. The compactor side is either a
// fixed stub value or a small MISR model that advances every clock.
module tb_sig_session_ctrl;

  localparam logic [15:0] ADDR_BASE = 16'h0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start;
  logic [15:0] num_words;
  logic [31:0] golden_sig;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic [31:0] mem_read_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout_err;
  logic [31:0] signature;
  logic [1:0]  dbg_state;

  sig_session_ctrl #(.ADDR_BASE(ADDR_BASE), .TIMEOUT(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .golden_sig(golden_sig), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_access_addr(mem_access_addr),
    .mem_write_data(mem_write_data), .mem_write_en(mem_write_en),
    .mem_read_data(mem_read_data), .busy(busy), .done(done), .pass(pass),
    .timeout_err(timeout_err), .signature(signature), .dbg_state(dbg_state)
  );

  // compactor stand-in
  logic        use_misr;
  logic [31:0] stub_val;
  logic [31:0] misr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misr_q <= 32'h0;
    else misr_q <= {misr_q[30:0], misr_q[31] ^ misr_q[21] ^ misr_q[1] ^ misr_q[0]}
                   ^ (mem_write_en ? {mem_access_addr, mem_write_data} : 32'h0);
  end
  assign mem_read_data = use_misr ? misr_q : stub_val;

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst_n && mem_write_en) begin
      if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else begin
        mon_exp = exp_q.pop_front();
        check("wr_addr_data", {mem_access_addr, mem_write_data}, mon_exp);
      end
    end
  end

  // driver tasks: all start and end at posedge+1
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [15:0] nw, input logic [31:0] g);
    start = 1'b1; num_words = nw; golden_sig = g;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input int gap);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Called during the READ cycle phase; checks READ, REPORT and after.
  task automatic check_read_report(input logic exp_pass, input logic [31:0] exp_sig);
    @(negedge clk);
    check("read_addr", {16'h0, mem_access_addr}, {16'h0, ADDR_BASE});
    check("read_we", {31'h0, mem_write_en}, 32'd0);
    check("read_ready", {31'h0, in_ready}, 32'd0);
    check("read_state", {30'h0, dbg_state}, 32'd2);
    check("read_done", {31'h0, done}, 32'd0);
    @(negedge clk);
    check("report_done", {31'h0, done}, 32'd1);
    check("report_busy", {31'h0, busy}, 32'd1);
    check("report_pass", {31'h0, pass}, {31'h0, exp_pass});
    check("report_sig", signature, exp_sig);
    check("report_to", {31'h0, timeout_err}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_busy", {31'h0, busy}, 32'd0);
    check("post_done", {31'h0, done}, 32'd0);
    check("post_pass_hold", {31'h0, pass}, {31'h0, exp_pass});
    @(posedge clk); #1;
  endtask

  int done_before;
  logic [31:0] sig1;

  initial begin
    rst_n = 1'b0; start = 1'b0; num_words = '0; golden_sig = '0;
    in_valid = 1'b0; in_data = '0; use_misr = 1'b0; stub_val = '0;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_ready", {31'h0, in_ready}, 32'd0);
    check("rst_addr", {16'h0, mem_access_addr}, 32'd0);
    check("rst_state", {30'h0, dbg_state}, 32'd0);
    check("rst_sig", signature, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // reset mid-session after 3 of 8 words
    do_start(16'd8, 32'h0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({ADDR_BASE + 16'(2 * i), 16'h0100 + 16'(i)});
      send_word(16'h0100 + 16'(i), 0);
    end
    check("mid_state", {30'h0, dbg_state}, 32'd1);
    done_before = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'h0, busy}, 32'd0);
    check("arst_ready", {31'h0, in_ready}, 32'd0);
    check("arst_state", {30'h0, dbg_state}, 32'd0);
    check("arst_addr", {16'h0, mem_access_addr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check("arst_no_done", done_cnt, done_before);
    check("arst_idle_busy", {31'h0, busy}, 32'd0);

    // basic back-to-back session
    stub_val = 32'hDEADBEEF;
    do_start(16'd4, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({ADDR_BASE + 16'(2 * i), 16'h1111 * 16'(i + 1)});
      send_word(16'h1111 * 16'(i + 1), 0);
    end
    check_read_report(1'b1, 32'hDEADBEEF);

    // mismatch with 2-cycle stalls between words
    stub_val = 32'h00000002;
    do_start(16'd3, 32'h00000001);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({ADDR_BASE + 16'(2 * i), 16'hC000 + 16'(i)});
      send_word(16'hC000 + 16'(i), (i < 2) ? 2 : 0);
    end
    check_read_report(1'b0, 32'h00000002);

    // zero length: straight to READ, no writes
    stub_val = 32'h00000003;
    do_start(16'd0, 32'h00000003);
    check_read_report(1'b1, 32'h00000003);

    // timeout after one word, with an ignored start mid-session
    do_start(16'd2, 32'h0);
    check("to_pass_cleared", {31'h0, pass}, 32'd0);
    exp_q.push_back({ADDR_BASE, 16'hBEEF});
    send_word(16'hBEEF, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("to_wait_done", {31'h0, done}, 32'd0);
      check("to_wait_state", {30'h0, dbg_state}, 32'd1);
      if (i == 2) begin start = 1'b1; num_words = 16'd0; end
      if (i == 3) start = 1'b0;
    end
    @(negedge clk);
    check("to_done", {31'h0, done}, 32'd1);
    check("to_err", {31'h0, timeout_err}, 32'd1);
    check("to_pass", {31'h0, pass}, 32'd0);
    check("to_sig_kept", signature, 32'h00000003);
    @(posedge clk); #1;
    @(negedge clk);
    check("to_post_busy", {31'h0, busy}, 32'd0);
    check("to_err_hold", {31'h0, timeout_err}, 32'd1);
    @(posedge clk); #1;

    // real compactor model: two identical runs from reset
    use_misr = 1'b1;
    sig1 = 32'h0;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      do_start(16'd16, sig1);
      for (int i = 0; i < 16; i++) begin
        exp_q.push_back({ADDR_BASE + 16'(2 * i), 16'hA5A5});
        send_word(16'hA5A5, 0);
      end
      if (run == 0) begin
        @(negedge clk);
        @(negedge clk);
        check("integ1_done", {31'h0, done}, 32'd1);
        sig1 = signature;
        @(posedge clk); #1;
      end else begin
        check_read_report(1'b1, sig1);
      end
    end

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sig_session_ctrl.md
Name: sig_session_ctrl

Overview:
Initiator-side sequencer for the response-compactor memory-mapped port (mem_access_addr / mem_write_data / mem_write_en / mem_read_data). It accepts a stream of 16-bit response words over a valid/ready handshake and issues one compactor write per accepted word. It then reads back the 32-bit raw signature and compares it against a golden value, reporting pass/fail. It sits between the core's test-response source and the compactor, replacing ad-hoc software pokes during BIST sessions.

Parameters:
ADDR_BASE, 16'h0000, start address of write sequence; bit0 must be 0.
TIMEOUT, 255, max consecutive COMPACT cycles with no accepted word before abort (0 = disabled).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle session start request; ignored unless idle.
num_words  input  16  words to compact this session; sampled on accepted start.
golden_sig  input  32  expected signature; sampled on accepted start.
in_valid  input  1  response word valid.
in_data  input  16  response word.
in_ready  output  1  block accepts word this cycle (in_valid & in_ready).
mem_access_addr  output  16  compactor address.
mem_write_data  output  16  compactor write data.
mem_write_en  output  1  compactor write strobe.
mem_read_data  input  32  compactor read data (combinational from address).
busy  output  1  session in progress.
done  output  1  one-cycle pulse at session end.
pass  output  1  result of last session; valid from done until next accepted start.
timeout_err  output  1  last session ended by timeout.
signature  output  32  captured signature of last session.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; mem_access_addr=16'h0000; counters and latched golden cleared. Reset mid-session abandons it silently; no done pulse.
- States: IDLE, COMPACT, READ, REPORT.
- IDLE: in_ready=0, mem_write_en=0, busy=0. start=1 -> latch num_words/golden_sig, clear pass/timeout_err, addr_idx=0, idle_cnt=0. Go to COMPACT, or to READ if num_words==0.
- COMPACT: busy=1, in_ready=1. Accepted word in cycle N drives, in cycle N, mem_write_en=1, mem_write_data=in_data, mem_access_addr=ADDR_BASE+addr_idx (16-bit wrap). These are combinational from in_data/in_valid and registered addr_idx. No write in a cycle without acceptance. Non-accept cycles: mem_write_en=0, mem_access_addr held at current value.
  - On accept: addr_idx+=2 (keeps bit0=0); word_cnt+=1; idle_cnt=0.
  - When word_cnt reaches num_words on an accept, go to READ next cycle.
  - Without accept, idle_cnt+=1. If TIMEOUT!=0 and idle_cnt reaches TIMEOUT, go to REPORT with timeout_err=1, pass=0, signature unchanged.
- READ (exactly one cycle): in_ready=0, mem_write_en=0, mem_access_addr=ADDR_BASE with bit0 forced 0 (raw signature view). signature<=mem_read_data at end of cycle; pass<=(mem_read_data==golden). Go to REPORT.
- REPORT (one cycle): done=1, busy=1. Go to IDLE; busy=0 from next cycle. pass/timeout_err/signature hold until next accepted start.
- Compactor state advances every clock whether or not written, so the signature is a function of word values, addresses, and the exact accept timing. The golden value must be generated with an identical stall pattern.
- start asserted in any non-IDLE state: ignored, no effect.
- in_valid in IDLE/READ/REPORT: not accepted (in_ready=0); data is neither consumed nor dropped by this block.
- num_words=16'hFFFF: word_cnt is 16-bit; the terminal compare is exact, so no overflow occurs.

Test Plan:
- Reset: assert rst_n=0 mid-COMPACT after 3 of 8 words -> all outputs 0 immediately, state IDLE, no done pulse; next start runs cleanly.
- Basic session: ADDR_BASE=0, num_words=4, words 16'h1111,2222,3333,4444 back-to-back; stub mem_read_data=32'hDEADBEEF, golden=32'hDEADBEEF -> writes on 4 consecutive cycles at addr 0,2,4,6 with matching data; READ addr=0; done pulse 2 cycles after last write; pass=1, signature=32'hDEADBEEF.
- Mismatch with stalls: num_words=3, in_valid gaps of 2 cycles between words, golden=32'h00000001, stub returns 32'h00000002 -> mem_write_en only on accept cycles; pass=0, signature=32'h00000002.
- Zero length: num_words=0, start -> COMPACT skipped; READ next cycle, done 2 cycles after start, no mem_write_en pulse.
- Timeout: TIMEOUT=5, num_words=2, one word then in_valid=0 -> done pulse after 5 idle cycles; timeout_err=1, pass=0; start during session ignored.
- Integration with real compactor: 16 words of 16'hA5A5 from reset, run twice with identical timing -> identical signatures, pass=1 when golden is taken from the first run.
